branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: BranchPredictor

---
 rtl/branch_predictor.sv | 71 +++++++
 tb/tb_branch_predictor.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped branch predictor with 2-bit counters and target buffer
module branch_predictor #(
    parameter int ENTRIES    = 16,
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        update,
    input  logic [31:0] update_pc,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        branch_estimation,
    output logic [31:0] predicted_pc
);

    localparam int TAG_BITS = 32 - INDEX_BITS - 2;

    logic [1:0]          counter [ENTRIES];
    logic                valid   [ENTRIES];
    logic [TAG_BITS-1:0] tag     [ENTRIES];
    logic [31:0]         target  [ENTRIES];

    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] update_idx;
    logic [TAG_BITS-1:0]   lookup_tag;
    logic [TAG_BITS-1:0]   update_tag;
    logic                  update_hit;
    logic                  unused_low_bits;

    assign lookup_idx = pc[INDEX_BITS+1:2];
    assign update_idx = update_pc[INDEX_BITS+1:2];
    assign lookup_tag = pc[31:INDEX_BITS+2];
    assign update_tag = update_pc[31:INDEX_BITS+2];
    assign unused_low_bits = ^{pc[1:0], update_pc[1:0]};

    // Lookup reads registered state only, so a same-cycle update is seen next cycle.
    assign branch_estimation = valid[lookup_idx] && (tag[lookup_idx] == lookup_tag)
                               && counter[lookup_idx][1];
    assign predicted_pc      = branch_estimation ? target[lookup_idx] : pc + 32'd4;

    assign update_hit = valid[update_idx] && (tag[update_idx] == update_tag);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                counter[i] <= 2'b01;
                valid[i]   <= 1'b0;
                tag[i]     <= '0;
                target[i]  <= '0;
            end
        end else if (update) begin
            if (update_hit) begin
                if (branch_taken) begin
                    if (counter[update_idx] != 2'b11)
                        counter[update_idx] <= counter[update_idx] + 2'b01;
                    target[update_idx] <= branch_target;
                end else if (counter[update_idx] != 2'b00) begin
                    counter[update_idx] <= counter[update_idx] - 2'b01;
                end
            end else if (branch_taken) begin
                // Only taken branches allocate; the previous occupant is evicted.
                valid[update_idx]   <= 1'b1;
                tag[update_idx]     <= update_tag;
                target[update_idx]  <= branch_target;
                counter[update_idx] <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed bench with reference predictor model
module tb_branch_predictor;
    localparam int ENTRIES    = 16;
    localparam int INDEX_BITS = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'h100;
    logic        update = 1'b0;
    logic [31:0] update_pc = 32'h0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        branch_estimation;
    logic [31:0] predicted_pc;

    int total = 0;
    int bad = 0;

    branch_predictor #(.ENTRIES(ENTRIES), .INDEX_BITS(INDEX_BITS)) dut (
        .clk(clk), .reset(reset), .pc(pc), .update(update), .update_pc(update_pc),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .branch_estimation(branch_estimation), .predicted_pc(predicted_pc)
    );

    always #5 clk = ~clk;

    // Reference model: a table keyed by index holding plain integers.
    int          m_ctr   [ENTRIES];
    bit          m_valid [ENTRIES];
    longint      m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    bit          armed = 1'b0;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 4) % ENTRIES);
    endfunction

    function automatic longint tag_of(input logic [31:0] a);
        return longint'(a) / (4 * ENTRIES);
    endfunction

    function automatic bit model_est(input logic [31:0] a);
        int i;
        i = idx_of(a);
        return m_valid[i] && (m_tag[i] == tag_of(a)) && (m_ctr[i] >= 2);
    endfunction

    function automatic logic [31:0] model_next(input logic [31:0] a);
        longint n;
        if (model_est(a)) return m_tgt[idx_of(a)];
        n = (longint'(a) + 4) % 64'h1_0000_0000;
        return n[31:0];
    endfunction

    always @(posedge clk) begin
        int i;
        if (reset) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_ctr[k] = 1; m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0;
            end
            armed = 1'b1;
        end else if (update) begin
            i = idx_of(update_pc);
            if (m_valid[i] && m_tag[i] == tag_of(update_pc)) begin
                if (branch_taken) begin
                    m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = branch_target;
                end else begin
                    m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
                end
            end else if (branch_taken) begin
                m_valid[i] = 1; m_tag[i] = tag_of(update_pc); m_tgt[i] = branch_target; m_ctr[i] = 2;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("model_est", {31'd0, branch_estimation}, {31'd0, model_est(pc)});
            chk("model_pc", predicted_pc, model_next(pc));
        end
    end

    task automatic drive(input logic rst, input logic [31:0] p, input logic upd,
                         input logic [31:0] upc, input logic tk, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        reset = rst; pc = p; update = upd; update_pc = upc;
        branch_taken = tk; branch_target = tgt;
    endtask

    task automatic expect_out(input string name, input logic est, input logic [31:0] npc);
        @(negedge clk);
        #1;
        chk({name, "_est"}, {31'd0, branch_estimation}, {31'd0, est});
        chk({name, "_pc"}, predicted_pc, npc);
    endtask

    initial begin
        drive(1, 32'h100, 0, 0, 0, 0);
        drive(1, 32'h100, 0, 0, 0, 0);
        drive(0, 32'h100, 0, 0, 0, 0);
        expect_out("reset_lookup", 0, 32'h104);

        drive(0, 32'h100, 1, 32'h100, 1, 32'h80);
        expect_out("alloc_same_cycle", 0, 32'h104);
        drive(0, 32'h100, 0, 0, 0, 0);
        expect_out("alloc_hit", 1, 32'h80);
        chk("alloc_ctr", m_ctr[0], 2);
        drive(0, 32'h140, 0, 0, 0, 0);
        expect_out("tag_miss", 0, 32'h144);

        drive(0, 32'h100, 1, 32'h100, 0, 0);
        drive(0, 32'h100, 1, 32'h100, 0, 0);
        drive(0, 32'h100, 0, 0, 0, 0);
        expect_out("ctr_00", 0, 32'h104);
        chk("ctr_floor", m_ctr[0], 0);
        drive(0, 32'h100, 1, 32'h100, 1, 32'h80);
        drive(0, 32'h100, 1, 32'h100, 1, 32'h80);
        drive(0, 32'h100, 1, 32'h100, 1, 32'h200);
        drive(0, 32'h100, 0, 0, 0, 0);
        expect_out("ctr_11", 1, 32'h200);
        chk("ctr_three", m_ctr[0], 3);
        drive(0, 32'h100, 1, 32'h100, 1, 32'h200);
        drive(0, 32'h100, 1, 32'h100, 0, 0);
        drive(0, 32'h100, 0, 0, 0, 0);
        expect_out("ctr_sat_down", 1, 32'h200);
        chk("ctr_two", m_ctr[0], 2);

        drive(0, 32'h100, 1, 32'h100, 0, 0);
        expect_out("no_bypass_old", 1, 32'h200);
        drive(0, 32'h100, 0, 0, 0, 0);
        expect_out("no_bypass_new", 0, 32'h104);

        drive(0, 32'h100, 1, 32'h100, 1, 32'h200);
        drive(0, 32'h100, 0, 0, 0, 0);
        expect_out("retaken", 1, 32'h200);
        drive(1, 32'h100, 1, 32'h100, 0, 0);
        drive(0, 32'h100, 0, 0, 0, 0);
        expect_out("reset_priority", 0, 32'h104);
        chk("reset_ctr", m_ctr[0], 1);
        chk("reset_valid", {31'd0, m_valid[0]}, 32'd0);

        drive(0, 32'h204, 1, 32'h204, 0, 0);
        drive(0, 32'h204, 0, 0, 0, 0);
        expect_out("no_alloc_nt", 0, 32'h208);
        drive(0, 32'h100, 1, 32'h100, 1, 32'h80);
        drive(0, 32'h100, 1, 32'h140, 1, 32'h300);
        drive(0, 32'h140, 0, 0, 0, 0);
        expect_out("replace_hit", 1, 32'h300);
        drive(0, 32'h100, 0, 0, 0, 0);
        expect_out("replace_evicted", 0, 32'h104);

        drive(0, 32'hFFFF_FFFC, 0, 0, 0, 0);
        expect_out("wrap", 0, 32'h0);
        drive(0, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 1, 32'h1000);
        drive(0, 32'hFFFF_FFFC, 0, 0, 0, 0);
        expect_out("wrap_hit", 1, 32'h1000);
        drive(0, 32'h3C, 0, 0, 0, 0);
        expect_out("wrap_other_tag", 0, 32'h40);

        @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
